wb_cmd_master: RTL and testbench

- Wishbone classic single-transfer initiator (bus master).
- Converts a valid/ready command stream into one Wishbone read or write cycle at a time, then returns a response (read data plus error flag) on a valid/ready response stream.
- Sits between a simple requester (debug bridge, boot loader, test sequencer) and SoC Wishbone peripherals such as the timer and other wb_* slaves.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_timeout_cnt.sv | 30 +++
 rtl/wb_cmd_master.sv | 117 +++++++++++
 tb/tb_wb_cmd_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and bus widths for the Wishbone command master and its helpers.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   // Data returned with a response whenever the access did not complete cleanly.
   localparam logic [WB_DAT_W-1:0] WB_RSP_ERR_DATA = 32'h0;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog for the command master: counts cycles spent waiting for ack/err
// and flags the last cycle before the configured limit is reached.
module wb_timeout_cnt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

   logic [15:0] count;

   // Expiry is flagged one count early so the abort lands on the edge ending cycle LIMIT.
   assign expired = enable && (count == LIMIT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Optional bus watchdog enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                i_wb_clk,
   input  logic                i_wb_rst_n,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic                i_cmd_we,
   input  logic [WB_ADR_W-1:0] i_cmd_adr,
   input  logic [WB_DAT_W-1:0] i_cmd_dat,
   input  logic [WB_SEL_W-1:0] i_cmd_sel,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [WB_DAT_W-1:0] o_rsp_dat,
   output logic                o_rsp_err,
   output logic                o_busy,
   output logic [WB_ADR_W-1:0] o_wb_adr,
   output logic [WB_DAT_W-1:0] o_wb_dat,
   output logic [WB_SEL_W-1:0] o_wb_sel,
   output logic                o_wb_we,
   output logic                o_wb_cyc,
   output logic                o_wb_stb,
   input  logic                i_wb_ack,
   input  logic                i_wb_err,
   input  logic [WB_DAT_W-1:0] i_wb_dat
);

   state_t state;
   logic   tmo_expired;

   assign o_cmd_ready = (state == IDLE);
   assign o_busy      = (state != IDLE);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   // Held clear outside BUS, so every bus cycle starts counting from zero.
   wb_timeout_cnt #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk    (i_wb_clk),
      .rst_n  (i_wb_rst_n),
      .clear  (state != BUS),
      .enable (state == BUS),
      .expired(tmo_expired)
   );
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         state       <= IDLE;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_adr    <= '0;
         o_wb_dat    <= '0;
         o_wb_sel    <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_err   <= 1'b0;
         o_rsp_dat   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_cmd_valid) begin
                  o_wb_we  <= i_cmd_we;
                  o_wb_adr <= i_cmd_adr;
                  o_wb_dat <= i_cmd_dat;
                  o_wb_sel <= i_cmd_sel;
                  o_wb_cyc <= 1'b1;
                  o_wb_stb <= 1'b1;
                  state    <= BUS;
               end
            end
            BUS: begin
               // err beats ack, and any real completion beats the watchdog.
               if (i_wb_err) begin
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_rsp_err   <= 1'b1;
                  o_rsp_dat   <= WB_RSP_ERR_DATA;
                  o_rsp_valid <= 1'b1;
                  state       <= RESP;
               end else if (i_wb_ack) begin
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_rsp_err   <= 1'b0;
                  o_rsp_dat   <= o_wb_we ? '0 : i_wb_dat;
                  o_rsp_valid <= 1'b1;
                  state       <= RESP;
               end else if (tmo_expired) begin
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_rsp_err   <= 1'b1;
                  o_rsp_dat   <= WB_RSP_ERR_DATA;
                  o_rsp_valid <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed, table-driven bench for wb_cmd_master plus hand-written corner-case sequences.
module tb_wb_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        busy;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_ack;
   logic        wb_err;
   logic [31:0] wb_dat_i;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   wb_cmd_master #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .i_wb_clk   (clk),
      .i_wb_rst_n (rst_n),
      .i_cmd_valid(cmd_valid),
      .o_cmd_ready(cmd_ready),
      .i_cmd_we   (cmd_we),
      .i_cmd_adr  (cmd_adr),
      .i_cmd_dat  (cmd_dat),
      .i_cmd_sel  (cmd_sel),
      .o_rsp_valid(rsp_valid),
      .i_rsp_ready(rsp_ready),
      .o_rsp_dat  (rsp_dat),
      .o_rsp_err  (rsp_err),
      .o_busy     (busy),
      .o_wb_adr   (wb_adr),
      .o_wb_dat   (wb_dat_o),
      .o_wb_sel   (wb_sel),
      .o_wb_we    (wb_we),
      .o_wb_cyc   (wb_cyc),
      .o_wb_stb   (wb_stb),
      .i_wb_ack   (wb_ack),
      .i_wb_err   (wb_err),
      .i_wb_dat   (wb_dat_i)
   );

   // One command plus the slave behaviour and the response we expect back.
   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          ack_delay;
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] exp_dat;
      logic        exp_err;
      int          exp_stb;
      int          rsp_wait;
   } vec_t;

   vec_t vecs[8];
   int   nvec;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_delay, input logic ack,
                         input logic err, input logic [31:0] rdata, input logic [31:0] exp_dat,
                         input logic exp_err, input int exp_stb, input int rsp_wait);
      vecs[nvec] = '{we, adr, dat, sel, ack_delay, ack, err, rdata, exp_dat, exp_err,
                     exp_stb, rsp_wait};
      nvec++;
   endtask

   // Drives one full command/bus/response transaction and checks it at every negedge.
   task automatic applyStimulus(input vec_t v);
      int  stb_cycles;
      bit  done;
      stb_cycles = 0;
      done       = 1'b0;
      @(negedge clk);
      checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_we    = v.we;
      cmd_adr   = v.adr;
      cmd_dat   = v.dat;
      cmd_sel   = v.sel;
      rsp_ready = (v.rsp_wait == 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_adr   = 32'hFFFF_FFFF;
      checkOutput("bus_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bus_busy", 32'(busy), 32'd1);
      checkOutput("bus_cyc", 32'(wb_cyc), 32'd1);
      checkOutput("bus_dat", wb_dat_o, v.dat);
      checkOutput("bus_sel", 32'(wb_sel), 32'(v.sel));
      checkOutput("bus_we", 32'(wb_we), 32'(v.we));
      for (int c = 0; c < 200; c++) begin
         if (rsp_valid) begin
            done = 1'b1;
            break;
         end
         if (wb_stb) begin
            stb_cycles++;
            checkOutput("bus_adr", wb_adr, v.adr);
            if (stb_cycles == v.ack_delay) begin
               wb_ack   = v.ack;
               wb_err   = v.err;
               wb_dat_i = v.rdata;
            end
         end
         @(negedge clk);
         wb_ack   = 1'b0;
         wb_err   = 1'b0;
         wb_dat_i = 32'hBAD0_BAD0;
      end
      checkOutput("rsp_arrived", 32'(done), 32'd1);
      checkOutput("stb_cycles", 32'(stb_cycles), 32'(v.exp_stb));
      checkOutput("rsp_dat", rsp_dat, v.exp_dat);
      checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      checkOutput("rsp_stb_low", 32'(wb_stb), 32'd0);
      checkOutput("rsp_cyc_low", 32'(wb_cyc), 32'd0);
      for (int k = 0; k < v.rsp_wait; k++) begin
         @(negedge clk);
         checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_rsp_dat", rsp_dat, v.exp_dat);
         checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b1;
      wb_ack    = 1'b0;
      wb_err    = 1'b0;
      wb_dat_i  = '0;
      nvec      = 0;

      addVec(1'b1, 32'h4,   32'h1234_5678, 4'hF, 1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1, 0);
      addVec(1'b0, 32'h4,   32'h0,         4'hF, 1, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1, 0);
      addVec(1'b0, 32'h100, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 5);
      addVec(1'b0, 32'h8,   32'h0,         4'hF, 1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h0,         1'b1, 1, 0);
      addVec(1'b1, 32'hC,   32'h5555_AAAA, 4'h3, 2, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 2, 0);
      addVec(1'b1, 32'h10,  32'h0F0F_0F0F, 4'h5, 2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 2, 0);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      addVec(1'b0, 32'h40,  32'h0,         4'hF, 0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 4, 0);
      addVec(1'b0, 32'h44,  32'h0,         4'hF, 4, 1'b1, 1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 4, 0);
`else
      addVec(1'b0, 32'h40,  32'h0,         4'hF, 20, 1'b1, 1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 20, 0);
`endif

      // Reset values, observed without any clock edge having taken effect.
      #12;
      checkOutput("rst_cyc", 32'(wb_cyc), 32'd0);
      checkOutput("rst_stb", 32'(wb_stb), 32'd0);
      checkOutput("rst_we", 32'(wb_we), 32'd0);
      checkOutput("rst_adr", wb_adr, 32'd0);
      checkOutput("rst_dat", wb_dat_o, 32'd0);
      checkOutput("rst_sel", 32'(wb_sel), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("rst_rsp_dat", rsp_dat, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < nvec; i++) begin
         applyStimulus(vecs[i]);
      end

      // A command held during RESP is taken only on the edge after the response handshake.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h8;
      cmd_sel   = 4'hF;
      rsp_ready = 1'b0;
      @(negedge clk);
      cmd_we   = 1'b1;
      cmd_adr  = 32'hC;
      cmd_dat  = 32'h0BAD_F00D;
      wb_ack   = 1'b1;
      wb_dat_i = 32'h0000_0011;
      @(negedge clk);
      wb_ack = 1'b0;
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_dat", rsp_dat, 32'h0000_0011);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         checkOutput("hold_adr", wb_adr, 32'h8);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("hold_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("hold_idle_cyc", 32'(wb_cyc), 32'd0);
      checkOutput("hold_idle_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("hold_second_cyc", 32'(wb_cyc), 32'd1);
      checkOutput("hold_second_adr", wb_adr, 32'hC);
      checkOutput("hold_second_we", 32'(wb_we), 32'd1);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      checkOutput("hold_second_rsp", 32'(rsp_valid), 32'd1);
      @(negedge clk);

      // A slave that keeps ack high after the bus cycle ends must not create extra responses.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_adr   = 32'h20;
      cmd_dat   = 32'hCAFE_0000;
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("stale_stb", 32'(wb_stb), 32'd1);
      wb_ack = 1'b1;
      @(negedge clk);
      checkOutput("stale_first_rsp", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      checkOutput("stale_no_rsp_resp", 32'(rsp_valid), 32'd0);
      checkOutput("stale_idle", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      checkOutput("stale_no_rsp_idle", 32'(rsp_valid), 32'd0);
      checkOutput("stale_no_cyc", 32'(wb_cyc), 32'd0);
      wb_ack = 1'b0;

      // Asynchronous reset in the middle of a bus cycle.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h30;
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("arst_pre_stb", 32'(wb_stb), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_cyc", 32'(wb_cyc), 32'd0);
      checkOutput("arst_stb", 32'(wb_stb), 32'd0);
      checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("arst_release_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      checkOutput("arst_no_rsp", 32'(rsp_valid), 32'd0);
      applyStimulus(vecs[1]);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
